// File: rtl/button_pkg.sv
// Shared event codes, FSM states and counter sizing helper for the button event controller.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } btn_evt_t;

  typedef enum logic [1:0] {
    BS_IDLE      = 2'd0,
    BS_PRESSED   = 2'd1,
    BS_REPEATING = 2'd2
  } btn_state_t;

  // Counter must hold values up to max(hold, repeat) - 1.
  function automatic int cnt_width(input int hold, input int rep);
    int m;
    m = (hold > rep) ? hold : rep;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_hold_fsm.sv
// Per-button edge detector and hold FSM; emits a combinational event code in the edge/expiry cycle.
// BUTTON_REPEAT_EN adds the REPEATING state and hold counter; otherwise only PRESS/RELEASE.
module btn_hold_fsm
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     btn,
  output btn_evt_t evt
);

  logic       btn_prev;
  btn_state_t state;
  logic       rise;
  logic       fall;

  assign rise = btn & ~btn_prev;
  assign fall = ~btn & btn_prev;

`ifdef BUTTON_REPEAT_EN

  localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= 1'b0;
      state    <= BS_IDLE;
      count    <= '0;
    end else begin
      btn_prev <= btn;
      case (state)
        BS_IDLE: begin
          count <= '0;
          if (rise) state <= BS_PRESSED;
        end
        BS_PRESSED: begin
          // A release wins over a same-cycle hold expiry.
          if (fall) begin
            state <= BS_IDLE;
            count <= '0;
          end else if (count == HOLD_LAST) begin
            state <= BS_REPEATING;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        BS_REPEATING: begin
          if (fall) begin
            state <= BS_IDLE;
            count <= '0;
          end else if (count == REP_LAST) begin
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= BS_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  always_comb begin
    evt = EVT_NONE;
    case (state)
      BS_IDLE:      if (rise) evt = EVT_PRESS;
      BS_PRESSED: begin
        if (fall)                    evt = EVT_RELEASE;
        else if (count == HOLD_LAST) evt = EVT_REPEAT;
      end
      BS_REPEATING: begin
        if (fall)                   evt = EVT_RELEASE;
        else if (count == REP_LAST) evt = EVT_REPEAT;
      end
      default:      evt = EVT_NONE;
    endcase
  end

`else

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= 1'b0;
      state    <= BS_IDLE;
    end else begin
      btn_prev <= btn;
      case (state)
        BS_IDLE:    if (rise) state <= BS_PRESSED;
        BS_PRESSED: if (fall) state <= BS_IDLE;
        default:    state <= BS_IDLE;
      endcase
    end
  end

  always_comb begin
    evt = EVT_NONE;
    case (state)
      BS_IDLE:    if (rise) evt = EVT_PRESS;
      BS_PRESSED: if (fall) evt = EVT_RELEASE;
      default:    evt = EVT_NONE;
    endcase
  end

`endif

endmodule

// File: rtl/button_event_ctrl.sv
// Serializes PRESS/REPEAT/RELEASE events from N debounced buttons onto one valid/ready port via round-robin.
// Edge at t -> pending at t+1 -> evt_valid at t+2; stalls hold the output; REPEAT needs BUTTON_REPEAT_EN.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  localparam int IW           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_clean,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW-1:0]    evt_id,
  output btn_evt_t         evt_type,
  output logic             evt_drop
);

  if (N_BTN < 1 || N_BTN > 16 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("button_event_ctrl: parameter out of range");
  end

  btn_evt_t      gen_evt [N_BTN];
  btn_evt_t      pend    [N_BTN];
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic          found;
  logic          load;
  logic          gnt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_hold_fsm #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_fsm (
      .clk(clk),
      .rst(rst),
      .btn(btn_clean[i]),
      .evt(gen_evt[i])
    );
  end

  assign load = ~evt_valid | evt_ready;
  assign gnt  = found & load;

  // Search starts one past the last winner so every button gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (!found && pend[idx] != EVT_NONE) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  // A new event replaces any unissued one; the register being issued this cycle is not a loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) pend[i] <= EVT_NONE;
      evt_drop <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (gen_evt[i] != EVT_NONE) begin
          pend[i] <= gen_evt[i];
          if (pend[i] != EVT_NONE && !(gnt && gnt_idx == IW'(i))) evt_drop <= 1'b1;
        end else if (gnt && gnt_idx == IW'(i)) begin
          pend[i] <= EVT_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EVT_NONE;
      rr_ptr    <= IW'(N_BTN - 1);
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_id   <= gnt_idx;
        evt_type <= pend[gnt_idx];
        rr_ptr   <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural event model.
module tb_button_event_ctrl;
  import button_pkg::*;

  localparam int N = 4;
  localparam int H = 8;
  localparam int R = 4;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic         ready = 1'b1;
  logic         valid;
  logic [1:0]   id;
  logic [1:0]   typ;
  logic         drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hq[$];

  // model state: what the outputs should be after each edge
  int m_valid = 0, m_id = 0, m_type = 0, m_drop = 0, m_rr = N - 1;
  int m_pend[N];
  int m_prev[N];
  int m_k[N];

  button_event_ctrl #(
    .N_BTN(N), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .btn_clean(btn), .evt_valid(valid),
    .evt_ready(ready), .evt_id(id), .evt_type(typ), .evt_drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int c, input int i, input int t);
    return c * 16 + i * 4 + t;
  endfunction

  task automatic model_step();
    int ev[N];
    int g;
    if (rst) begin
      m_valid = 0; m_id = 0; m_type = 0; m_drop = 0; m_rr = N - 1;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_prev[i] = 0; m_k[i] = 0;
      end
    end else begin
      g = -1;
      if (!m_valid || ready)
        for (int j = 1; j <= N; j++)
          if (g < 0 && m_pend[(m_rr + j) % N] != 0) g = (m_rr + j) % N;
      for (int i = 0; i < N; i++) begin
        ev[i] = 0;
        if (btn[i] && m_prev[i] == 0) begin
          ev[i] = 1; m_k[i] = 0;
        end else if (!btn[i] && m_prev[i] != 0) begin
          ev[i] = 3;
        end else if (btn[i]) begin
          m_k[i]++;
          if (REP && m_k[i] >= H && (m_k[i] - H) % R == 0) ev[i] = 2;
        end
      end
      if (!m_valid || ready) begin
        if (g >= 0) begin
          m_valid = 1; m_id = g; m_type = m_pend[g]; m_rr = g;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ev[i] != 0) begin
          if (m_pend[i] != 0 && i != g) m_drop = 1;
          m_pend[i] = ev[i];
        end else if (i == g) begin
          m_pend[i] = 0;
        end
        m_prev[i] = int'(btn[i]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (valid && ready && !rst) hq.push_back(enc(cyc, int'(id), int'(typ)));
    @(posedge clk);
    model_step();
    #1;
    chk("valid", valid, m_valid);
    chk("drop", drop, m_drop);
    chk("id", id, m_id);
    chk("type", typ, m_type);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
    hq.delete();
  endtask

  task automatic cmp_hq(input string tag, input int exp[$]);
    chk({tag, "_count"}, hq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < hq.size()) ? hq[i] : -1, exp[i]);
  endtask

  initial begin
    int exp[$];
    int n_press, n_rep, n_rel, exp_rep;

    // reset state
    btn = '0; ready = 1'b1;
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_type", typ, 0);
    chk("rst_drop", drop, 0);

    // 1: single button press, hold, release
    for (int c = 0; c < 55; c++) begin
      btn[0] = (c >= 10 && c <= 40);
      step();
    end
    exp.delete();
    exp.push_back(enc(12, 0, 1));
    if (REP) for (int c = 20; c <= 40; c += 4) exp.push_back(enc(c, 0, 2));
    exp.push_back(enc(43, 0, 3));
    cmp_hq("t1_events", exp);

    // 2: simultaneous press/release on btn1 and btn3
    do_reset();
    for (int c = 0; c < 16; c++) begin
      btn = (c >= 3 && c <= 6) ? 4'b1010 : 4'b0000;
      step();
    end
    exp.delete();
    exp.push_back(enc(5, 1, 1));
    exp.push_back(enc(6, 3, 1));
    exp.push_back(enc(9, 1, 3));
    exp.push_back(enc(10, 3, 3));
    cmp_hq("t2_rr", exp);

    // 3: consumer stalled while btn2 is pressed and released
    do_reset();
    for (int c = 0; c < 30; c++) begin
      btn   = (c < 12) ? 4'b0100 : 4'b0000;
      ready = (c >= 20);
      step();
      if (c >= 2 && c <= 18) begin
        chk("t3_hold_id", id, 2);
        chk("t3_hold_type", typ, 1);
        chk("t3_hold_valid", valid, 1);
      end
    end
    chk("t3_drop", drop, REP);
    exp.delete();
    exp.push_back(enc(20, 2, 1));
    exp.push_back(enc(21, 2, 3));
    cmp_hq("t3_events", exp);
    ready = 1'b1;

    // 4: button held through reset
    rst = 1'b1; btn = 4'b0001;
    repeat (3) step();
    rst = 1'b0; cyc = 0; hq.delete();
    for (int c = 0; c < 10; c++) begin
      btn[0] = (c < 5);
      step();
    end
    exp.delete();
    exp.push_back(enc(2, 0, 1));
    exp.push_back(enc(7, 0, 3));
    cmp_hq("t4_events", exp);

    // 5: reset while an event is being presented
    do_reset();
    btn = 4'b0001;
    for (int c = 0; c < 10; c++) step();
    chk("t5_pre_valid", valid, REP);
    rst = 1'b1;
    step();
    chk("t5_valid", valid, 0);
    chk("t5_id", id, 0);
    chk("t5_type", typ, 0);
    chk("t5_drop", drop, 0);
    step();
    rst = 1'b0; cyc = 0; hq.delete();
    for (int c = 0; c < 5; c++) step();
    exp.delete();
    exp.push_back(enc(2, 0, 1));
    cmp_hq("t5_fresh_press", exp);
    btn = '0;

    // 6: long hold; REPEAT count follows the hold/repeat arithmetic
    do_reset();
    for (int c = 0; c < 115; c++) begin
      btn[0] = (c >= 2 && c < 102);
      step();
    end
    n_press = 0; n_rep = 0; n_rel = 0;
    foreach (hq[i]) begin
      if (hq[i] % 4 == 1) n_press++;
      if (hq[i] % 4 == 2) n_rep++;
      if (hq[i] % 4 == 3) n_rel++;
    end
    exp_rep = 0;
    if (REP) for (int k = 1; k < 100; k++) if (k >= H && (k - H) % R == 0) exp_rep++;
    chk("t6_press", n_press, 1);
    chk("t6_repeat", n_rep, exp_rep);
    chk("t6_release", n_rel, 1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
